// File: rtl/render_scheduler_if.sv
// Signal bundle between render_scheduler (master) and its requester, solver array and pixel sink.
interface render_scheduler_if;
  logic signed [26:0] req_min_x, req_min_y, req_max_x, req_max_y, req_dx, req_dy;
  logic               req_valid;
  logic               req_ready;
  logic signed [26:0] min_x, min_y, max_x, max_y, dx, dy;
  logic               solver_reset;
  logic               solvers_done;
  logic [5:0]         rd_solver_id;
  logic [18:0]        rd_addr;
  logic [7:0]         rd_data;
  logic               pix_valid;
  logic               pix_ready;
  logic [7:0]         pix_data;
  logic [18:0]        pix_index;
  logic               pix_last;
  logic               busy;
  logic               timeout;

  modport master (
    input  req_min_x, req_min_y, req_max_x, req_max_y, req_dx, req_dy, req_valid,
    input  solvers_done, rd_data, pix_ready,
    output req_ready, min_x, min_y, max_x, max_y, dx, dy, solver_reset,
    output rd_solver_id, rd_addr, pix_valid, pix_data, pix_index, pix_last, busy, timeout
  );

  modport slave (
    output req_min_x, req_min_y, req_max_x, req_max_y, req_dx, req_dy, req_valid,
    output solvers_done, rd_data, pix_ready,
    input  req_ready, min_x, min_y, max_x, max_y, dx, dy, solver_reset,
    input  rd_solver_id, rd_addr, pix_valid, pix_data, pix_index, pix_last, busy, timeout
  );
endinterface

// File: rtl/render_scheduler.sv
// Frame scheduler: accepts a view, resets and waits on the solver array, then streams pixels.
// Define SOLVE_TIMEOUT_EN to add a sticky solve watchdog (TIMEOUT_CYCLES).
module render_scheduler #(
  parameter int unsigned NUM_SOLVERS    = 4,
  parameter int unsigned NUM_PIXELS     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
  input logic                clock,
  input logic                reset,
  render_scheduler_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StSolve = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [5:0]  SolMax  = 6'(NUM_SOLVERS - 1);
  localparam logic [18:0] AddrMax = 19'(NUM_PIXELS / NUM_SOLVERS - 1);
  localparam logic [18:0] PixMax  = 19'(NUM_PIXELS - 1);

  logic [1:0]         state_q, state_d;
  logic               load_cnt_q, load_cnt_d;
  logic [1:0]         guard_q, guard_d;
  logic signed [26:0] view_q [6];
  logic signed [26:0] view_d [6];
  logic signed [26:0] req_view [6];

  logic [5:0]  sol_q, sol_d;
  logic [18:0] addr_q, addr_d;
  logic        iss_done_q, iss_done_d;
  logic        infl_q, infl_d;
  logic [7:0]  buf_q [2];
  logic [7:0]  buf_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [18:0] idx_q, idx_d;

  logic       accept, guard_ok, done_ok, wd_expire;
  logic       pop, issue, last_xfer;
  logic [2:0] occ;

  assign req_view[0] = bus.req_min_x;
  assign req_view[1] = bus.req_min_y;
  assign req_view[2] = bus.req_max_x;
  assign req_view[3] = bus.req_max_y;
  assign req_view[4] = bus.req_dx;
  assign req_view[5] = bus.req_dy;

  assign bus.min_x = view_q[0];
  assign bus.min_y = view_q[1];
  assign bus.max_x = view_q[2];
  assign bus.max_y = view_q[3];
  assign bus.dx    = view_q[4];
  assign bus.dy    = view_q[5];

  assign bus.req_ready    = (state_q == StIdle) & ~reset;
  assign bus.busy         = (state_q != StIdle);
  assign bus.solver_reset = (state_q == StLoad);

  assign accept   = bus.req_valid & bus.req_ready;
  // A done flag left over from the previous frame is ignored for two SOLVE cycles.
  assign guard_ok = (guard_q == 2'd2);
  assign done_ok  = (state_q == StSolve) & guard_ok & bus.solvers_done;

  assign bus.pix_valid    = (cnt_q != 2'd0);
  assign bus.pix_data     = buf_q[rd_ptr_q];
  assign bus.pix_index    = idx_q;
  assign bus.pix_last     = bus.pix_valid & (idx_q == PixMax);
  assign bus.rd_solver_id = sol_q;
  assign bus.rd_addr      = addr_q;

  assign pop       = bus.pix_valid & bus.pix_ready;
  assign last_xfer = pop & (idx_q == PixMax);
  // Occupancy after this cycle's pop; keeps the 2-entry buffer full-rate without overflow.
  assign occ       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue     = (state_q == StDrain) & ~iss_done_q & (occ < 3'd2);

  always_comb begin
    state_d    = state_q;
    load_cnt_d = 1'b0;
    guard_d    = 2'd0;
    view_d     = view_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          view_d  = req_view;
        end
      end
      StLoad: begin
        load_cnt_d = ~load_cnt_q;
        if (load_cnt_q) state_d = StSolve;
      end
      StSolve: begin
        guard_d = guard_ok ? guard_q : guard_q + 2'd1;
        if (done_ok)        state_d = StDrain;
        else if (wd_expire) state_d = StIdle;
      end
      StDrain: begin
        if (last_xfer) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sol_d      = 6'd0;
    addr_d     = 19'd0;
    iss_done_d = 1'b0;
    infl_d     = 1'b0;
    buf_d      = buf_q;
    wr_ptr_d   = 1'b0;
    rd_ptr_d   = 1'b0;
    cnt_d      = 2'd0;
    idx_d      = 19'd0;
    if (state_q == StDrain) begin
      sol_d      = sol_q;
      addr_d     = addr_q;
      iss_done_d = iss_done_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      idx_d      = idx_q;
      infl_d     = issue;
      cnt_d      = occ[1:0];
      // Solver id wraps and carries into the per-solver address.
      if (issue) begin
        if (sol_q == SolMax) begin
          sol_d = 6'd0;
          if (addr_q == AddrMax) iss_done_d = 1'b1;
          else                   addr_d     = addr_q + 19'd1;
        end else begin
          sol_d = sol_q + 6'd1;
        end
      end
      if (infl_q) begin
        buf_d[wr_ptr_q] = bus.rd_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        idx_d    = idx_q + 19'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      load_cnt_q <= 1'b0;
      guard_q    <= 2'd0;
      view_q     <= '{default: '0};
      sol_q      <= 6'd0;
      addr_q     <= 19'd0;
      iss_done_q <= 1'b0;
      infl_q     <= 1'b0;
      buf_q      <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      idx_q      <= 19'd0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      guard_q    <= guard_d;
      view_q     <= view_d;
      sol_q      <= sol_d;
      addr_q     <= addr_d;
      iss_done_q <= iss_done_d;
      infl_q     <= infl_d;
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
    end
  end

`ifdef SOLVE_TIMEOUT_EN
  localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wdog_q, wdog_d;
  logic           timeout_q, timeout_d;

  assign wd_expire   = (state_q == StSolve) & (wdog_q == WdLast);
  assign bus.timeout = timeout_q;

  always_comb begin
    wdog_d    = (state_q == StSolve) ? wdog_q + 1'b1 : '0;
    timeout_d = timeout_q | (wd_expire & ~done_ok);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_render_scheduler.sv
// Randomized bench for render_scheduler against a frame-level model of the pixel stream.
module tb_render_scheduler;
  localparam int unsigned NS = 4;
  localparam int unsigned NP = 16;
  localparam int unsigned TO = 100;

  logic clock = 1'b0;
  logic reset;

  render_scheduler_if bus ();

  render_scheduler #(
    .NUM_SOLVERS   (NS),
    .NUM_PIXELS    (NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Solver array contents: each byte carries its solver id and address in the top nibble.
  logic [7:0] mem [NS][NP/NS];

  task automatic fill_mem();
    for (int s = 0; s < int'(NS); s++)
      for (int a = 0; a < int'(NP / NS); a++)
        mem[s][a] = {2'(s), 2'(a), 4'($urandom)};
  endtask

  function automatic logic [7:0] exp_pix(input int p);
    return mem[p % NS][p / NS];
  endfunction

  always @(posedge clock) begin
    if (bus.rd_solver_id < 6'(NS) && bus.rd_addr < 19'(NP / NS))
      bus.rd_data <= mem[bus.rd_solver_id[1:0]][bus.rd_addr[1:0]];
    else
      bus.rd_data <= 8'hEE;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int sr_run = 0, sr_len = 0, solve_cnt = 0, solve_cyc = 0, fv_cyc = 0;
  int xfer_cnt = 0, first_xfer_cyc = 0, last_xfer_cyc = 0, frames_cnt = 0, exp_idx = 0;
  bit want_fv = 0, prev_stall = 0, prev_sr = 0;
  logic [7:0]  prev_data;
  logic [18:0] prev_idx;
  logic        prev_last;

  always @(negedge clock) begin
    if (reset) begin
      exp_idx    = 0;
      prev_stall = 0;
      sr_run     = 0;
      prev_sr    = 0;
      want_fv    = 0;
    end else begin
      if (bus.solver_reset) sr_run++;
      else if (prev_sr) begin
        sr_len    = sr_run;
        sr_run    = 0;
        solve_cnt++;
        solve_cyc = cyc;
        want_fv   = 1;
      end
      prev_sr = bus.solver_reset;
      if (want_fv && bus.pix_valid) begin
        fv_cyc  = cyc;
        want_fv = 0;
      end
      if (prev_stall) begin
        check_eq("stall_valid", 64'(bus.pix_valid), 64'd1);
        check_eq("stall_data", 64'(bus.pix_data), 64'(prev_data));
        check_eq("stall_index", 64'(bus.pix_index), 64'(prev_idx));
        check_eq("stall_last", 64'(bus.pix_last), 64'(prev_last));
      end
      if (bus.pix_valid && bus.pix_ready) begin
        check_eq("pix_index", 64'(bus.pix_index), 64'(exp_idx));
        check_eq("pix_data", 64'(bus.pix_data), 64'(exp_pix(exp_idx)));
        check_eq("pix_last", 64'(bus.pix_last), 64'(exp_idx == int'(NP) - 1));
        if (exp_idx == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
        if (exp_idx == int'(NP) - 1) begin
          exp_idx = 0;
          frames_cnt++;
        end else begin
          exp_idx++;
        end
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_data  = bus.pix_data;
      prev_idx   = bus.pix_index;
      prev_last  = bus.pix_last;
    end
  end

  int rdy_mode = 0;
  int phase    = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    phase++;
    case (rdy_mode)
      0:       bus.pix_ready = 1'b1;
      1:       bus.pix_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: bus.pix_ready = 1'($urandom_range(1));
    endcase
  endtask

  function automatic logic [161:0] rand_view();
    logic [161:0] v;
    for (int i = 0; i < 6; i++) v[i*27 +: 27] = 27'($urandom);
    return v;
  endfunction

  function automatic logic [161:0] dut_view();
    return {bus.min_x, bus.min_y, bus.max_x, bus.max_y, bus.dx, bus.dy};
  endfunction

  task automatic check_view(input string tag, input logic [161:0] exp);
    logic [161:0] got;
    got = dut_view();
    for (int i = 0; i < 6; i++) check_eq(tag, 64'(got[i*27 +: 27]), 64'(exp[i*27 +: 27]));
  endtask

  task automatic drive_req(input logic [161:0] v);
    {bus.req_min_x, bus.req_min_y, bus.req_max_x, bus.req_max_y, bus.req_dx, bus.req_dy} = v;
    bus.req_valid = 1'b1;
  endtask

  task automatic send_req(input logic [161:0] v);
    int n = 0;
    drive_req(v);
    while (!bus.req_ready && n < 500) begin
      tick();
      n++;
    end
    check_eq("req_ready_wait", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    check_eq("busy_after_accept", 64'(bus.busy), 64'd1);
    check_view("view_capture", v);
  endtask

  task automatic wait_solve(input int snap);
    int n = 0;
    while (solve_cnt == snap && n < 100) begin
      tick();
      n++;
    end
    check_eq("solve_start_seen", 64'(solve_cnt != snap), 64'd1);
  endtask

  task automatic wait_frame(input int snap);
    int n = 0;
    while (frames_cnt == snap && n < 2000) begin
      tick();
      n++;
    end
    check_eq("frame_done_seen", 64'(frames_cnt != snap), 64'd1);
  endtask

  task automatic run_frame(input int mode, input int done_dly, input bit done_pre);
    logic [161:0] v;
    int s0, f0, x0;
    v = rand_view();
    fill_mem();
    rdy_mode = mode;
    s0 = solve_cnt;
    f0 = frames_cnt;
    x0 = xfer_cnt;
    bus.solvers_done = done_pre;
    send_req(v);
    wait_solve(s0);
    check_eq("solver_reset_len", 64'(sr_len), 64'd2);
    if (!done_pre) repeat (done_dly) tick();
    bus.solvers_done = 1'b1;
    wait_frame(f0);
    check_eq("idle_after_last", 64'(bus.busy), 64'd0);
    check_eq("ready_after_last", 64'(bus.req_ready), 64'd1);
    check_eq("pix_count", 64'(xfer_cnt - x0), 64'(NP));
    check_eq("stale_done_guard", 64'((fv_cyc - solve_cyc) >= 4), 64'd1);
    check_view("view_hold", v);
    if (mode == 0) check_eq("back_to_back", 64'(last_xfer_cyc - first_xfer_cyc), 64'(NP - 1));
    bus.solvers_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [161:0] va, vb;
    int s0, s1, f0, x0, n;
    reset = 1'b1;
    bus.req_valid    = 1'b0;
    bus.solvers_done = 1'b0;
    bus.pix_ready    = 1'b1;
    drive_req(162'd0);
    bus.req_valid = 1'b0;
    fill_mem();
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
    check_eq("rst_pix_last", 64'(bus.pix_last), 64'd0);
    check_eq("rst_solver_reset", 64'(bus.solver_reset), 64'd0);
    check_eq("rst_timeout", 64'(bus.timeout), 64'd0);
    check_view("rst_view", 162'd0);
    reset = 1'b0;
    tick();
    check_eq("ready_after_reset", 64'(bus.req_ready), 64'd1);

    run_frame(0, 9, 1'b0);
    run_frame(1, 3, 1'b0);
    run_frame(0, 0, 1'b1);
    for (int i = 0; i < 3; i++) run_frame(2, int'($urandom_range(15)), 1'b0);

    // Second request presented during DRAIN.
    va = rand_view();
    vb = rand_view();
    fill_mem();
    rdy_mode = 0;
    s0 = solve_cnt;
    f0 = frames_cnt;
    x0 = xfer_cnt;
    send_req(va);
    wait_solve(s0);
    s1 = solve_cnt;
    bus.solvers_done = 1'b1;
    n = 0;
    while (xfer_cnt - x0 < 3 && n < 300) begin
      tick();
      n++;
    end
    drive_req(vb);
    n = 0;
    while (frames_cnt == f0 && n < 300) begin
      check_eq("req_ready_in_drain", 64'(bus.req_ready), 64'd0);
      check_view("view_during_drain", va);
      tick();
      n++;
    end
    check_eq("ready_in_idle", 64'(bus.req_ready), 64'd1);
    check_view("view_before_second", va);
    tick();
    bus.req_valid = 1'b0;
    check_eq("second_accepted", 64'(bus.busy), 64'd1);
    check_view("view_second", vb);
    wait_solve(s1);
    wait_frame(f0 + 1);
    check_eq("second_pix_count", 64'(xfer_cnt - x0), 64'(2 * NP));
    bus.solvers_done = 1'b0;

    // Reset while pixel 7 is on the stream.
    fill_mem();
    rdy_mode = 0;
    s0 = solve_cnt;
    f0 = frames_cnt;
    x0 = xfer_cnt;
    send_req(rand_view());
    wait_solve(s0);
    bus.solvers_done = 1'b1;
    n = 0;
    while (xfer_cnt - x0 < 7 && n < 300) begin
      tick();
      n++;
    end
    check_eq("at_pixel7_valid", 64'(bus.pix_valid), 64'd1);
    check_eq("at_pixel7_index", 64'(bus.pix_index), 64'd7);
    reset = 1'b1;
    #1;
    check_eq("midreset_pix_valid", 64'(bus.pix_valid), 64'd0);
    check_eq("midreset_busy", 64'(bus.busy), 64'd0);
    check_eq("midreset_solver_reset", 64'(bus.solver_reset), 64'd0);
    check_view("midreset_view", 162'd0);
    tick();
    tick();
    reset = 1'b0;
    bus.solvers_done = 1'b0;
    tick();
    check_eq("ready_after_midreset", 64'(bus.req_ready), 64'd1);
    repeat (30) tick();
    check_eq("no_pix_after_reset", 64'(xfer_cnt - x0), 64'd7);
    check_eq("no_frame_after_reset", 64'(frames_cnt - f0), 64'd0);

`ifdef SOLVE_TIMEOUT_EN
    s0 = solve_cnt;
    x0 = xfer_cnt;
    bus.solvers_done = 1'b0;
    send_req(rand_view());
    wait_solve(s0);
    n = 0;
    while (!bus.timeout && n < 300) begin
      tick();
      n++;
    end
    check_eq("timeout_latency", 64'(n), 64'(TO - 1));
    check_eq("timeout_busy", 64'(bus.busy), 64'd0);
    check_eq("timeout_ready", 64'(bus.req_ready), 64'd1);
    repeat (5) tick();
    check_eq("timeout_sticky", 64'(bus.timeout), 64'd1);
    check_eq("timeout_no_pix", 64'(xfer_cnt - x0), 64'd0);
    reset = 1'b1;
    #1;
    check_eq("timeout_cleared", 64'(bus.timeout), 64'd0);
    tick();
    reset = 1'b0;
    tick();
`else
    s0 = solve_cnt;
    f0 = frames_cnt;
    bus.solvers_done = 1'b0;
    send_req(rand_view());
    wait_solve(s0);
    repeat (150) tick();
    check_eq("solve_waits_busy", 64'(bus.busy), 64'd1);
    check_eq("solve_waits_no_timeout", 64'(bus.timeout), 64'd0);
    bus.solvers_done = 1'b1;
    wait_frame(f0);
    bus.solvers_done = 1'b0;
`endif
    run_frame(2, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 SHALL have parameter NUM_SOLVERS, default 4, number of solvers in the attached solver array (1..64).
REQ-002 SHALL have parameter NUM_PIXELS, default 1024, pixels per frame (multiple of NUM_SOLVERS, at most 2^19).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2^24, solve watchdog limit (used only under SOLVE_TIMEOUT_EN).
REQ-004 SHALL have port clock  input  1  single clock; all flops on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_min_x, req_min_y, req_max_x, req_max_y, req_dx, req_dy  input  27 each, signed  view window of a frame request.
REQ-007 SHALL have port req_valid  input  1, and req_ready  output  1  frame-request handshake.
REQ-008 SHALL have ports min_x, min_y, max_x, max_y, dx, dy  output  27 each, signed  registered view driven to the solver array.
REQ-009 SHALL have port solver_reset  output  1  synchronous reset pulse to the solver array.
REQ-010 SHALL have port solvers_done  input  1  all-solvers-done flag from the array.
REQ-011 SHALL have ports rd_solver_id  output  6, rd_addr  output  19, rd_data  input  8  array readout; rd_data is valid one cycle after the address.
REQ-012 SHALL have ports pix_valid  output  1, pix_ready  input  1, pix_data  output  8, pix_index  output  19, pix_last  output  1  pixel stream.
REQ-013 SHALL have ports busy  output  1 (state != IDLE) and timeout  output  1 (sticky error flag).

Function
REQ-014 SHALL implement states IDLE, LOAD, SOLVE, DRAIN.
REQ-015 SHALL, in IDLE only, assert req_ready; on req_valid&req_ready it SHALL capture all six view inputs into the view outputs and go to LOAD.
REQ-016 SHALL, in LOAD, assert solver_reset for exactly 2 cycles, then enter SOLVE; view outputs stay stable from capture until the next accepted request.
REQ-017 SHALL, in SOLVE, ignore solvers_done during the first 2 cycles (stale-done guard), then go to DRAIN on the first cycle solvers_done=1.
REQ-018 SHALL map pixel p to rd_solver_id = p mod NUM_SOLVERS and rd_addr = p / NUM_SOLVERS, using a solver counter wrapping at NUM_SOLVERS-1 that carries into an address counter (no divider).
REQ-019 SHALL, in DRAIN, issue a read only when buffered pixels plus the in-flight read total fewer than 2 (2-entry skid buffer), sustaining 1 pixel/cycle with pix_ready held high.
REQ-020 SHALL present pixels in order p = 0..NUM_PIXELS-1 with pix_index = p and pix_last = 1 only for p = NUM_PIXELS-1.
REQ-021 SHALL hold pix_data, pix_index, pix_last stable while pix_valid=1 and pix_ready=0; a pixel transfers on pix_valid&pix_ready.
REQ-022 SHALL return to IDLE on the cycle after the pix_last transfer; the next request is accepted no earlier than that IDLE cycle.
REQ-023 SHALL drop no pixel and duplicate no pixel under any pix_ready pattern.
REQ-024 SHALL ignore req_valid outside IDLE (request held by the requester, req_ready=0).

Reset
REQ-025 SHALL, on reset assertion, immediately force state IDLE, counters 0, skid buffer empty, view outputs 0, solver_reset 0, pix_valid 0, pix_last 0, busy 0, timeout 0; req_ready 1 once reset deasserts.
REQ-026 SHALL abandon any frame in progress when reset asserts mid-LOAD/SOLVE/DRAIN; no pixel of that frame is emitted afterward.

Configuration
REQ-027 SHALL, with SOLVE_TIMEOUT_EN defined, count SOLVE cycles; at TIMEOUT_CYCLES without solvers_done it SHALL set timeout=1 (sticky until reset), emit no pixels, and return to IDLE.
REQ-028 SHALL, without SOLVE_TIMEOUT_EN, have no watchdog counter, tie timeout to 0, and wait in SOLVE indefinitely.

Verification
REQ-029 SHALL cover: NUM_SOLVERS=4, NUM_PIXELS=16, one request, solvers_done rising 10 cycles into SOLVE, pix_ready=1 -> 16 pixels on consecutive cycles, index 0..15, pixel 5 read from solver 1 addr 1, pix_last only on index 15.
REQ-030 SHALL cover: pix_ready toggling 1,0,0,1 repeatedly -> all 16 pixels exactly once in order, outputs stable during stalls.
REQ-031 SHALL cover: solvers_done held 1 from before the request -> DRAIN entered no earlier than 3 cycles into SOLVE; solver_reset high exactly 2 cycles.
REQ-032 SHALL cover: second req_valid during DRAIN -> req_ready=0, not accepted until IDLE, then view outputs update to the second request.
REQ-033 SHALL cover: reset asserted at pixel 7 of DRAIN -> pix_valid=0 at once, state IDLE, no further pixels of that frame.
REQ-034 SHALL cover (SOLVE_TIMEOUT_EN, TIMEOUT_CYCLES=100): solvers_done held 0 -> timeout=1 after 100 SOLVE cycles, zero pixels, busy=0, req_ready=1.
